// File: rtl/alu_op_sequencer_if.sv
// Command/response/ALU bus of the ALU operation sequencer.
// slave = sequencer side, master = command source / ALU harness side.
interface alu_op_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [1:0]   cmd_sel;
  logic         cmd_use_acc;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_y;
  logic         busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, rsp_ready, alu_y,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, rsp_ready, alu_y,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for a 4-op combinational ALU: IDLE -> EXEC -> RESP.
// Optional accumulator operand substitution enabled by defining ALU_SEQ_ACC_EN.
module alu_op_sequencer #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  alu_op_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int CW = (SETTLE + 1 > 2) ? $clog2(SETTLE + 1) : 1;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  alu_a_reg;
  logic [W-1:0]  alu_b_reg;
  logic [1:0]    alu_sel_reg;
  logic          rsp_valid_reg;
  logic [W-1:0]  rsp_data_reg;
  logic          rsp_zero_reg;
  logic [W-1:0]  a_next;
  logic          capture;

  assign capture = (state_reg == EXEC) && (cnt_reg == '0);

`ifdef ALU_SEQ_ACC_EN
  logic [W-1:0] acc_reg;

  assign a_next = bus.cmd_use_acc ? acc_reg : bus.cmd_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (capture) begin
      acc_reg <= bus.alu_y;
    end
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = bus.cmd_use_acc;
  assign a_next         = bus.cmd_a;
`endif

  // The counter is loaded with SETTLE and AluY is sampled once it reaches 0,
  // so the operand registers drive the ALU for SETTLE full cycles plus the
  // load cycle: accept at edge k gives RspValid after edge k+SETTLE+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_sel_reg   <= 2'b00;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_reg   <= a_next;
            alu_b_reg   <= bus.cmd_b;
            alu_sel_reg <= bus.cmd_sel;
            cnt_reg     <= CW'(SETTLE);
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            rsp_data_reg  <= bus.alu_y;
            rsp_zero_reg  <= (bus.alu_y == '0);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_zero  = rsp_zero_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_sel   = alu_sel_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (W=4, SETTLE=1) with a behavioural ALU attached.
// Accumulator expectations follow ALU_SEQ_ACC_EN when the bench is built with it.
module tb_alu_op_sequencer;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_op_sequencer_if #(.W(W)) intf ();

  alu_op_sequencer #(.W(W), .SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 00 add, 01 sub, 10 or, 11 and, all modulo 2^W
  always_comb begin
    intf.alu_y = '0;
    case (intf.alu_sel)
      2'b00: intf.alu_y = intf.alu_a + intf.alu_b;
      2'b01: intf.alu_y = intf.alu_a - intf.alu_b;
      2'b10: intf.alu_y = intf.alu_a | intf.alu_b;
      default: intf.alu_y = intf.alu_a & intf.alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with rsp_ready=1: accept, two EXEC edges, handshake.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                         input logic use_acc, input logic [3:0] exp_alu_a,
                         input logic [3:0] exp_data, input logic exp_zero);
    intf.cmd_valid   = 1'b1;
    intf.cmd_a       = a;
    intf.cmd_b       = b;
    intf.cmd_sel     = sel;
    intf.cmd_use_acc = use_acc;
    check("cmd_ready_idle", 8'(intf.cmd_ready), 8'h1);
    tick();
    intf.cmd_valid = 1'b0;
    check("busy_exec", 8'(intf.busy), 8'h1);
    check("alu_a_load", 8'(intf.alu_a), 8'(exp_alu_a));
    check("alu_sel_load", 8'(intf.alu_sel), 8'(sel));
    check("rsp_valid_k", 8'(intf.rsp_valid), 8'h0);
    tick();
    check("rsp_valid_k1", 8'(intf.rsp_valid), 8'h0);
    tick();
    check("rsp_valid_k2", 8'(intf.rsp_valid), 8'h1);
    check("rsp_data", 8'(intf.rsp_data), 8'(exp_data));
    check("rsp_zero", 8'(intf.rsp_zero), 8'(exp_zero));
    $display("txn a=%0h b=%0h sel=%0d use_acc=%0d -> data=%0h zero=%0d",
             a, b, sel, use_acc, intf.rsp_data, intf.rsp_zero);
    tick();
    check("rsp_valid_after_hs", 8'(intf.rsp_valid), 8'h0);
    check("cmd_ready_after_hs", 8'(intf.cmd_ready), 8'h1);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    intf.cmd_valid   = 1'b0;
    intf.cmd_a       = '0;
    intf.cmd_b       = '0;
    intf.cmd_sel     = 2'b00;
    intf.cmd_use_acc = 1'b0;
    intf.rsp_ready   = 1'b1;
    #1;
    check("reset_cmd_ready", 8'(intf.cmd_ready), 8'h1);
    check("reset_rsp_valid", 8'(intf.rsp_valid), 8'h0);
    check("reset_busy", 8'(intf.busy), 8'h0);
    check("reset_alu_a", 8'(intf.alu_a), 8'h0);
    check("reset_rsp_data", 8'(intf.rsp_data), 8'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic add, wrap to zero, two's complement sub, or, and
    run_cmd(4'h3, 4'h4, 2'b00, 1'b0, 4'h3, 4'h7, 1'b0);
    run_cmd(4'h7, 4'h9, 2'b00, 1'b0, 4'h7, 4'h0, 1'b1);
    run_cmd(4'h3, 4'h5, 2'b01, 1'b0, 4'h3, 4'hE, 1'b0);
    run_cmd(4'hA, 4'h5, 2'b10, 1'b0, 4'hA, 4'hF, 1'b0);
    run_cmd(4'hA, 4'h5, 2'b11, 1'b0, 4'hA, 4'h0, 1'b1);

    // back-pressure: response held while rsp_ready=0, pending command waits
    intf.rsp_ready = 1'b0;
    intf.cmd_valid = 1'b1;
    intf.cmd_a     = 4'h1;
    intf.cmd_b     = 4'h2;
    intf.cmd_sel   = 2'b00;
    tick();
    intf.cmd_a   = 4'h6;
    intf.cmd_b   = 4'h1;
    intf.cmd_sel = 2'b01;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 8'(intf.rsp_valid), 8'h1);
      check("bp_rsp_data", 8'(intf.rsp_data), 8'h3);
      check("bp_cmd_ready", 8'(intf.cmd_ready), 8'h0);
      check("bp_alu_a_held", 8'(intf.alu_a), 8'h1);
      tick();
    end
    $display("txn a=1 b=2 sel=0 held 5 cycles -> data=%0h", intf.rsp_data);
    intf.rsp_ready = 1'b1;
    tick();
    check("bp_hs_rsp_valid", 8'(intf.rsp_valid), 8'h0);
    check("bp_hs_idle", 8'(intf.busy), 8'h0);
    tick();
    intf.cmd_valid = 1'b0;
    check("bp_pending_taken", 8'(intf.busy), 8'h1);
    check("bp_pending_alu_a", 8'(intf.alu_a), 8'h6);
    tick();
    tick();
    check("bp_pending_valid", 8'(intf.rsp_valid), 8'h1);
    check("bp_pending_data", 8'(intf.rsp_data), 8'h5);
    $display("txn a=6 b=1 sel=1 (pending) -> data=%0h", intf.rsp_data);
    tick();

    // asynchronous reset mid-EXEC discards the command
    intf.cmd_valid = 1'b1;
    intf.cmd_a     = 4'h9;
    intf.cmd_b     = 4'h3;
    intf.cmd_sel   = 2'b10;
    tick();
    intf.cmd_valid = 1'b0;
    check("pre_reset_busy", 8'(intf.busy), 8'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_busy", 8'(intf.busy), 8'h0);
    check("mid_reset_cmd_ready", 8'(intf.cmd_ready), 8'h1);
    check("mid_reset_alu_a", 8'(intf.alu_a), 8'h0);
    check("mid_reset_alu_sel", 8'(intf.alu_sel), 8'h0);
    check("mid_reset_rsp_data", 8'(intf.rsp_data), 8'h0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_no_rsp", 8'(intf.rsp_valid), 8'h0);
    end
    $display("txn a=9 b=3 sel=2 discarded by reset");

    // accumulator substitution (acc cleared by the reset above)
    run_cmd(4'h2, 4'h3, 2'b00, 1'b0, 4'h2, 4'h5, 1'b0);
`ifdef ALU_SEQ_ACC_EN
    run_cmd(4'h1, 4'h4, 2'b00, 1'b1, 4'h5, 4'h9, 1'b0);
`else
    run_cmd(4'h1, 4'h4, 2'b00, 1'b1, 4'h1, 4'h5, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
